sqrt_req_arbiter: RTL and testbench

//   Shares one fully pipelined integer square-root core among NREQ requesters.

---
 rtl/sqrt_req_arbiter.sv | 159 +++++++++++++++
 tb/tb_sqrt_req_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_req_arbiter.sv
// Round-robin front end that shares one pipelined sqrt core among NREQ requesters.
// A tag pipe follows each issued operand so its root is routed back to the requester that sent it.
module sqrt_req_arbiter #(
   parameter int DW      = 16,
   parameter int NREQ    = 4,
   parameter int LAT     = 16,
   parameter int MAX_OUT = 4
) (
   input  logic                   i_Sys_clk,
   input  logic                   i_Rst,
   input  logic [NREQ-1:0]        i_Req_valid,
   input  logic [NREQ*DW-1:0]     i_Req_data,
   output logic [NREQ-1:0]        o_Req_ready,
   output logic                   o_Core_valid,
   output logic [DW-1:0]          o_Core_din,
   input  logic                   i_Core_valid,
   input  logic [DW/2-1:0]        i_Core_root,
   output logic [NREQ-1:0]        o_Rsp_valid,
   output logic [NREQ*DW/2-1:0]   o_Rsp_root,
   output logic                   o_Busy,
   output logic                   o_Err
);
   localparam int RW  = DW / 2;
   localparam int IDW = $clog2(NREQ);
   localparam int CW  = $clog2(MAX_OUT + 1);
   localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_OUT);
   localparam logic [IDW:0]   NREQ_W  = (IDW + 1)'(NREQ);
   localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

   logic [IDW-1:0] ptr_reg;
   logic [CW-1:0]  out_cnt_reg [NREQ];
   logic           tag_valid_reg [LAT+1];
   logic [IDW-1:0] tag_id_reg [LAT+1];
   logic           rsp_valid_reg [NREQ];
   logic [RW-1:0]  rsp_root_reg [NREQ];
   logic           err_reg;

   logic [NREQ-1:0] eligible;
   logic [NREQ-1:0] release_slot;
   logic            grant_found;
   logic [IDW-1:0]  grant_id;
   logic [IDW:0]    search_idx;
   logic            tag_out_valid;
   logic [IDW-1:0]  tag_out_id;

   // Stage 0 lines up with o_Core_valid, so stage LAT lines up with i_Core_valid.
   assign tag_out_valid = tag_valid_reg[LAT];
   assign tag_out_id    = tag_id_reg[LAT];

   // Scan from the highest offset down so the closest eligible requester to ptr wins.
   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      search_idx  = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         search_idx = {1'b0, ptr_reg} + (IDW + 1)'(i);
         if (search_idx >= NREQ_W)
            search_idx = search_idx - NREQ_W;
         if (eligible[search_idx[IDW-1:0]] && !i_Rst) begin
            grant_found = 1'b1;
            grant_id    = search_idx[IDW-1:0];
         end
      end
   end

   always_comb begin
      o_Req_ready = '0;
      if (grant_found)
         o_Req_ready[grant_id] = 1'b1;
   end

   always_ff @(posedge i_Sys_clk) begin
      if (i_Rst) begin
         ptr_reg      <= '0;
         o_Core_valid <= 1'b0;
         o_Core_din   <= '0;
      end else begin
         o_Core_valid <= grant_found;
         if (grant_found) begin
            ptr_reg    <= (grant_id == LAST_ID) ? '0 : grant_id + IDW'(1);
            o_Core_din <= i_Req_data[int'(grant_id) * DW +: DW];
         end
      end
   end

   always_ff @(posedge i_Sys_clk) begin
      if (i_Rst) begin
         tag_valid_reg[0] <= 1'b0;
         tag_id_reg[0]    <= '0;
      end else begin
         tag_valid_reg[0] <= grant_found;
         tag_id_reg[0]    <= grant_id;
      end
   end

   generate
      for (genvar gi = 1; gi <= LAT; gi++) begin : g_tag
         always_ff @(posedge i_Sys_clk) begin
            if (i_Rst) begin
               tag_valid_reg[gi] <= 1'b0;
               tag_id_reg[gi]    <= '0;
            end else begin
               tag_valid_reg[gi] <= tag_valid_reg[gi-1];
               tag_id_reg[gi]    <= tag_id_reg[gi-1];
            end
         end
      end
   endgenerate

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
         assign eligible[gi]     = i_Req_valid[gi] && (out_cnt_reg[gi] < MAX_CNT);
         // A tag leaving the pipe frees its slot even if the core failed to answer.
         assign release_slot[gi] = tag_out_valid && (tag_out_id == IDW'(gi));

         always_ff @(posedge i_Sys_clk) begin
            if (i_Rst)
               out_cnt_reg[gi] <= '0;
            else if (o_Req_ready[gi] && !release_slot[gi])
               out_cnt_reg[gi] <= out_cnt_reg[gi] + CW'(1);
            else if (release_slot[gi] && !o_Req_ready[gi])
               out_cnt_reg[gi] <= out_cnt_reg[gi] - CW'(1);
         end

         always_ff @(posedge i_Sys_clk) begin
            if (i_Rst) begin
               rsp_valid_reg[gi] <= 1'b0;
               rsp_root_reg[gi]  <= '0;
            end else begin
               rsp_valid_reg[gi] <= release_slot[gi] && i_Core_valid;
               if (release_slot[gi] && i_Core_valid)
                  rsp_root_reg[gi] <= i_Core_root;
            end
         end

         assign o_Rsp_valid[gi]            = rsp_valid_reg[gi];
         assign o_Rsp_root[gi*RW +: RW]    = rsp_root_reg[gi];
      end
   endgenerate

   always_ff @(posedge i_Sys_clk) begin
      if (i_Rst)
         err_reg <= 1'b0;
      else if (i_Core_valid != tag_out_valid)
         err_reg <= 1'b1;
   end

   assign o_Err = err_reg;

   always_comb begin
      o_Busy = 1'b0;
      for (int k = 0; k < NREQ; k++)
         if (out_cnt_reg[k] != '0)
            o_Busy = 1'b1;
      for (int s = 0; s <= LAT; s++)
         if (tag_valid_reg[s])
            o_Busy = 1'b1;
   end
endmodule

// File: tb/tb_sqrt_req_arbiter.sv
// Directed bench for sqrt_req_arbiter with a behavioural LAT-cycle sqrt core.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_sqrt_req_arbiter;
   localparam int DW      = 16;
   localparam int NREQ    = 4;
   localparam int LAT     = 16;
   localparam int MAX_OUT = 4;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [NREQ-1:0]      req_valid = '0;
   logic [NREQ*DW-1:0]   req_data = '0;
   logic [NREQ-1:0]      req_ready;
   logic                 core_valid;
   logic [DW-1:0]        core_din;
   logic                 core_valid_in;
   logic [DW/2-1:0]      core_root_in;
   logic [NREQ-1:0]      rsp_valid;
   logic [NREQ*DW/2-1:0] rsp_root;
   logic                 busy;
   logic                 err;
   logic                 inj = 1'b0;

   int total  = 0;
   int passed = 0;

   logic [15:0] rr_op   [4];
   logic [7:0]  rr_root [4];
   logic [3:0]  exp_rdy;

   always #5 clk = ~clk;

   sqrt_req_arbiter #(.DW(DW), .NREQ(NREQ), .LAT(LAT), .MAX_OUT(MAX_OUT)) dut (
      .i_Sys_clk    (clk),
      .i_Rst        (rst),
      .i_Req_valid  (req_valid),
      .i_Req_data   (req_data),
      .o_Req_ready  (req_ready),
      .o_Core_valid (core_valid),
      .o_Core_din   (core_din),
      .i_Core_valid (core_valid_in),
      .i_Core_root  (core_root_in),
      .o_Rsp_valid  (rsp_valid),
      .o_Rsp_root   (rsp_root),
      .o_Busy       (busy),
      .o_Err        (err)
   );

   // Behavioural sqrt core, reset together with the arbiter.
   function automatic logic [7:0] isqrt(input logic [15:0] x);
      logic [7:0] r;
      r = 8'd0;
      for (int i = 0; i < 256; i++)
         if (i * i <= int'(x))
            r = 8'(i);
      return r;
   endfunction

   logic [LAT-1:0] mc_valid;
   logic [7:0]     mc_root [LAT];

   always @(posedge clk) begin
      if (rst) begin
         mc_valid <= '0;
      end else begin
         mc_valid   <= {mc_valid[LAT-2:0], core_valid};
         mc_root[0] <= isqrt(core_din);
         for (int s = 1; s < LAT; s++)
            mc_root[s] <= mc_root[s-1];
      end
   end

   assign core_valid_in = mc_valid[LAT-1] | inj;
   assign core_root_in  = mc_root[LAT-1];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   initial begin
      rr_op[0] = 16'd0;     rr_root[0] = 8'd0;
      rr_op[1] = 16'd1;     rr_root[1] = 8'd1;
      rr_op[2] = 16'hFFFF;  rr_root[2] = 8'd255;
      rr_op[3] = 16'd10000; rr_root[3] = 8'd100;

      // Reset held with every requester asking.
      rst = 1'b1;
      req_valid = 4'hF;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         chk("rst_ready", req_ready, 4'b0000);
         chk("rst_core_valid", core_valid, 1'b0);
      end
      chk("rst_err", err, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 4'b0000);
      @(negedge clk); rst = 1'b0; #1;
      chk("first_grant", req_ready, 4'b0001);
      req_valid = 4'h0;

      // Single op from req2.
      @(negedge clk); req_valid = 4'b0100; req_data[32 +: 16] = 16'd144; #1;
      chk("single_ready", req_ready, 4'b0100);
      @(negedge clk); req_valid = 4'h0; #1;
      chk("single_core_valid", core_valid, 1'b1);
      chk("single_core_din", core_din, 16'd144);
      chk("single_busy", busy, 1'b1);
      repeat (LAT) @(negedge clk);
      #1;
      chk("single_early", rsp_valid, 4'b0000);
      @(negedge clk); #1;
      chk("single_rsp_valid", rsp_valid, 4'b0100);
      chk("single_root", rsp_root[16 +: 8], 8'd12);
      @(negedge clk); #1;
      chk("single_pulse_end", rsp_valid, 4'b0000);
      chk("single_root_hold", rsp_root[16 +: 8], 8'd12);
      chk("single_idle", busy, 1'b0);

      // Short reset so the pointer restarts at req0.
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;

      // Round-robin with all four requesters valid for 16 cycles.
      for (int k = 0; k < 4; k++)
         req_data[k*16 +: 16] = rr_op[k];
      for (int n = 0; n <= 16; n++) begin
         @(negedge clk);
         req_valid = (n < 16) ? 4'hF : 4'h0;
         #1;
         if (n < 16) begin
            exp_rdy = 4'b0001 << (n % 4);
            chk($sformatf("rr_ready_%0d", n), req_ready, exp_rdy);
         end
         if (n > 0) begin
            chk($sformatf("rr_core_valid_%0d", n), core_valid, 1'b1);
            chk($sformatf("rr_core_din_%0d", n), core_din, rr_op[(n-1) % 4]);
         end
      end
      for (int n = 17; n <= 33; n++) begin
         @(negedge clk); #1;
         if (n >= 18) begin
            exp_rdy = 4'b0001 << ((n - 18) % 4);
            chk($sformatf("rr_rsp_valid_%0d", n), rsp_valid, exp_rdy);
            chk($sformatf("rr_root_%0d", n), rsp_root[((n - 18) % 4) * 8 +: 8], rr_root[(n - 18) % 4]);
         end
      end
      @(negedge clk); #1;
      chk("rr_idle", busy, 1'b0);

      // Outstanding limit on req1 alone.
      req_data[16 +: 16] = 16'd49;
      for (int n = 0; n < 24; n++) begin
         @(negedge clk);
         req_valid = (n < 23) ? 4'b0010 : 4'b0000;
         #1;
         exp_rdy = (n < 4 || (n >= 18 && n < 22)) ? 4'b0010 : 4'b0000;
         if (n < 23)
            chk($sformatf("lim_ready_%0d", n), req_ready, exp_rdy);
         if (n >= 18 && n <= 21) begin
            chk($sformatf("lim_rsp_valid_%0d", n), rsp_valid, 4'b0010);
            chk($sformatf("lim_root_%0d", n), rsp_root[8 +: 8], 8'd7);
         end
      end
      repeat (17) @(negedge clk);
      #1;
      chk("lim_idle", busy, 1'b0);
      chk("lim_err", err, 1'b0);

      // Core strobe with an empty tag pipe.
      @(negedge clk); inj = 1'b1; #1;
      chk("perr_before", err, 1'b0);
      @(negedge clk); inj = 1'b0; #1;
      chk("perr_set", err, 1'b1);
      chk("perr_no_rsp", rsp_valid, 4'b0000);
      @(negedge clk); #1;
      chk("perr_sticky", err, 1'b1);
      chk("perr_idle", busy, 1'b0);

      // Reset in the middle of traffic.
      for (int n = 0; n < 3; n++) begin
         @(negedge clk); req_valid = 4'hF;
      end
      #1;
      chk("mid_busy", busy, 1'b1);
      chk("mid_err_held", err, 1'b1);
      @(negedge clk); rst = 1'b1; #1;
      chk("mid_rst_ready", req_ready, 4'b0000);
      @(negedge clk); rst = 1'b0; #1;
      chk("mid_busy_clr", busy, 1'b0);
      chk("mid_err_clr", err, 1'b0);
      chk("mid_core_valid", core_valid, 1'b0);
      chk("mid_ptr", req_ready, 4'b0001);
      req_valid = 4'h0;
      for (int n = 0; n < LAT + 4; n++) begin
         @(negedge clk); #1;
         chk($sformatf("mid_no_rsp_%0d", n), rsp_valid, 4'b0000);
      end
      chk("mid_err_final", err, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
